// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: CPSR flag layout,
// default widths and the NZCV flag vector type.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;
    localparam int FLAGS_W    = 4;

    localparam int CPSR_N = 31;
    localparam int CPSR_Z = 30;
    localparam int CPSR_C = 29;
    localparam int CPSR_V = 28;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for outstanding loads: one bit per register, set by lock
// issue, cleared by the load write-back port, with per-read-port busy outputs.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lock_en,
    input  logic [ADDR_W-1:0]        lock_addr,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit BYP   = (BYPASS != 0);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_set;
    logic [DEPTH-1:0] w_clr;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_dec
            assign w_set[gi] = lock_en && (lock_addr == ADDR_W'(gi));
            assign w_clr[gi] = wr1_en  && (wr1_addr  == ADDR_W'(gi));
        end
    endgenerate

    // A lock landing on the same edge as the load return means a new load is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_set | (r_busy & ~w_clr);
        end
    end

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            assign w_addr      = rd_addr[gi*ADDR_W +: ADDR_W];
            assign rd_busy[gi] = r_busy[w_addr] & ~(BYP & w_clr[w_addr] & ~w_set[w_addr]);
        end
    endgenerate

endmodule

// File: rtl/regfile_mp.sv
// CPU register file: NUM_RD combinational read ports, ALU (port 0) and load
// (port 1) write ports, NZCV CPSR and a load-busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     lock_en,
    input  logic [ADDR_W-1:0]        lock_addr,
    input  logic                     flags_we,
    input  logic [FLAGS_W-1:0]       flags_in,
    output logic [DATA_W-1:0]        cpsr,
    output logic                     wr_conflict
);

    localparam int DEPTH    = 1 << ADDR_W;
    localparam bit BYP      = (BYPASS != 0);
    localparam int FLAG_LSB = DATA_W - (DEF_DATA_W - CPSR_V);

    logic [DATA_W-1:0] r_regs [DEPTH];
    flags_t            r_flags;
    flags_t            w_flags;

    assign wr_conflict = wr0_en && wr1_en && (wr0_addr == wr1_addr);

    // Port 1 is written last so it wins a same-index collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_regs[k] <= '0;
            end
            r_flags <= '0;
        end else begin
            if (wr0_en) begin
                r_regs[wr0_addr] <= wr0_data;
            end
            if (wr1_en) begin
                r_regs[wr1_addr] <= wr1_data;
            end
            if (flags_we) begin
                r_flags <= flags_t'(flags_in);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic [DATA_W-1:0] w_data;
            assign w_addr = rd_addr[gi*ADDR_W +: ADDR_W];
            always_comb begin
                w_data = r_regs[w_addr];
                if (BYP && wr0_en && (wr0_addr == w_addr)) begin
                    w_data = wr0_data;
                end
                if (BYP && wr1_en && (wr1_addr == w_addr)) begin
                    w_data = wr1_data;
                end
                if (rst) begin
                    w_data = '0;
                end
            end
            assign rd_data[gi*DATA_W +: DATA_W] = w_data;
        end
    endgenerate

    always_comb begin
        w_flags = r_flags;
        if (BYP && flags_we) begin
            w_flags = flags_t'(flags_in);
        end
        cpsr = '0;
        if (!rst) begin
            cpsr[FLAG_LSB +: FLAGS_W] = w_flags;
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .lock_en   (lock_en),
        .lock_addr (lock_addr),
        .wr1_en    (wr1_en),
        .wr1_addr  (wr1_addr),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy)
    );

`ifdef REGFILE_TRACE
    always @(posedge clk) begin
        if (!rst) begin
            if (wr0_en && !wr_conflict) begin
                $display("regfile: r%0d <= 0x%h (alu)", wr0_addr, wr0_data);
            end
            if (wr1_en) begin
                $display("regfile: r%0d <= 0x%h (load)", wr1_addr, wr1_data);
            end
        end
    end
`endif

endmodule
